alu_op_queue: RTL and testbench

Request buffer between the instruction decode logic and the ALU. It stores up to DEPTH ALU requests of the form {opcode, operand A, operand B} in a circular FIFO. It presents the oldest request to the ALU through a valid/ready handshake, so decode keeps issuing while the ALU consumer stalls. Opcodes use the ALU encoding: ADD=0x0, SUB=0x1, AND=0x2, OR=0x3, XOR=0x4, SLL=0x5, SRL=0x6, SRA=0x7, SLT=0x8, SLTU=0x9, PASSB=0xA. Codes 0x0B–0xFF are illegal.

---
 rtl/alu_op_queue.sv | 126 ++++++++++++
 tb/tb_alu_op_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_queue.sv
`default_nettype none
// ============================================================================
// alu_op_queue : circular FIFO of {opcode, A, B} requests feeding the ALU.
// Optional macro ALU_OPQ_OPCHECK_EN drops (and counts) opcodes above 0x0A.
// Revision: 1.0
// ============================================================================
module alu_op_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_op,
  input  logic [DATA_WIDTH-1:0]      in_a,
  input  logic [DATA_WIDTH-1:0]      in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_op,
  output logic [DATA_WIDTH-1:0]      out_a,
  output logic [DATA_WIDTH-1:0]      out_b,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 illegal_cnt
);
  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [7:0]            op_q [DEPTH];
  logic [7:0]            op_d [DEPTH];
  logic [DATA_WIDTH-1:0] a_q  [DEPTH];
  logic [DATA_WIDTH-1:0] a_d  [DEPTH];
  logic [DATA_WIDTH-1:0] b_q  [DEPTH];
  logic [DATA_WIDTH-1:0] b_d  [DEPTH];

  logic w_push_hs, w_pop, w_legal, w_write;

  // Readiness comes from registered occupancy only, never from out_ready.
  assign in_ready  = (count_q < C_DEPTH);
  assign out_valid = (count_q != '0);
  assign out_op    = op_q[rd_ptr_q];
  assign out_a     = a_q[rd_ptr_q];
  assign out_b     = b_q[rd_ptr_q];
  assign count     = count_q;

  assign w_push_hs = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
`ifdef ALU_OPQ_OPCHECK_EN
  assign w_legal   = (in_op <= 8'h0A);
`else
  assign w_legal   = 1'b1;
`endif
  assign w_write   = w_push_hs && w_legal;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    if (w_write) begin
      op_d[wr_ptr_q] = in_op;
      a_d[wr_ptr_q]  = in_a;
      b_d[wr_ptr_q]  = in_b;
      wr_ptr_d       = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (w_write && !w_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!w_write && w_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i] <= '0;
        a_q[i]  <= '0;
        b_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

`ifdef ALU_OPQ_OPCHECK_EN
  logic [7:0] illegal_cnt_q, illegal_cnt_d;

  // Illegal requests are still handshaked; only the counter records them.
  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (w_push_hs && !w_legal && (illegal_cnt_q != 8'hFF)) begin
      illegal_cnt_d = illegal_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt_q <= '0;
    end else begin
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign illegal_cnt = illegal_cnt_q;
`else
  assign illegal_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_queue.sv
`default_nettype none
// ============================================================================
// tb_alu_op_queue : self-checking bench for alu_op_queue (vector table,
// directed corner sequences, randomized traffic against a queue model).
// Revision: 1.0
// ============================================================================
module tb_alu_op_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [7:0]    in_op, out_op, illegal_cnt;
  logic [DW-1:0] in_a, in_b, out_a, out_b;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  alu_op_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_a(out_a), .out_b(out_b),
    .count(count), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } req_t;

  typedef struct {
    logic          iv;
    logic [7:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          ordy;
    int            e_cnt;
    logic          e_ov;
    logic          e_irdy;
    logic          chk_d;
    logic [7:0]    e_op;
    logic [DW-1:0] e_a;
    logic [DW-1:0] e_b;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [7:0] op, logic [DW-1:0] a, logic [DW-1:0] b,
                              logic ordy, int e_cnt, logic e_ov, logic e_irdy, logic chk_d,
                              logic [7:0] e_op, logic [DW-1:0] e_a, logic [DW-1:0] e_b);
    vec_t v;
    v.iv = iv; v.op = op; v.a = a; v.b = b; v.ordy = ordy;
    v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_irdy = e_irdy; v.chk_d = chk_d;
    v.e_op = e_op; v.e_a = e_a; v.e_b = e_b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"},   64'(count),       64'd0);
    chk({tag, "_ovalid"},  64'(out_valid),   64'd0);
    chk({tag, "_iready"},  64'(in_ready),    64'd1);
    chk({tag, "_op"},      64'(out_op),      64'd0);
    chk({tag, "_a"},       64'(out_a),       64'd0);
    chk({tag, "_b"},       64'(out_b),       64'd0);
    chk({tag, "_illegal"}, 64'(illegal_cnt), 64'd0);
  endtask

  vec_t tbl[9];
  req_t mq[$];
  int   ill_model;

  initial begin
    // Directed vectors: single push/pop, fill to full, full with pop and retry.
    tbl[0] = mk(1, 8'h00, 32'd5,    32'd7,    0, 1, 1, 1, 1, 8'h00, 32'd5,    32'd7);
    tbl[1] = mk(0, 8'h00, 32'd0,    32'd0,    1, 0, 0, 1, 0, 8'h00, 32'd0,    32'd0);
    tbl[2] = mk(1, 8'h01, 32'h11,   32'h21,   0, 1, 1, 1, 1, 8'h01, 32'h11,   32'h21);
    tbl[3] = mk(1, 8'h02, 32'h12,   32'h22,   0, 2, 1, 1, 1, 8'h01, 32'h11,   32'h21);
    tbl[4] = mk(1, 8'h03, 32'h13,   32'h23,   0, 3, 1, 1, 1, 8'h01, 32'h11,   32'h21);
    tbl[5] = mk(1, 8'h04, 32'h14,   32'h24,   0, 4, 1, 0, 1, 8'h01, 32'h11,   32'h21);
    tbl[6] = mk(1, 8'h05, 32'h15,   32'h25,   0, 4, 1, 0, 1, 8'h01, 32'h11,   32'h21);
    tbl[7] = mk(1, 8'h05, 32'h15,   32'h25,   1, 3, 1, 1, 1, 8'h02, 32'h12,   32'h22);
    tbl[8] = mk(1, 8'h05, 32'h15,   32'h25,   0, 4, 1, 0, 1, 8'h02, 32'h12,   32'h22);

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0;
    #3;
    chk_reset_state("reset");
    do_reset();

    for (int i = 0; i < 9; i++) begin
      in_valid  = tbl[i].iv;
      in_op     = tbl[i].op;
      in_a      = tbl[i].a;
      in_b      = tbl[i].b;
      out_ready = tbl[i].ordy;
      tick();
      chk($sformatf("vec%0d_count", i),  64'(count),     64'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_ovalid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("vec%0d_iready", i), 64'(in_ready),  64'(tbl[i].e_irdy));
      if (tbl[i].chk_d) begin
        chk($sformatf("vec%0d_op", i), 64'(out_op), 64'(tbl[i].e_op));
        chk($sformatf("vec%0d_a", i),  64'(out_a),  64'(tbl[i].e_a));
        chk($sformatf("vec%0d_b", i),  64'(out_b),  64'(tbl[i].e_b));
      end
    end

    // Stream 10 SUB requests while out_ready toggles; pointers wrap twice.
    do_reset();
    begin
      int sent = 0;
      int got  = 0;
      for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
        logic acc;
        in_valid  = (sent < 10);
        in_op     = 8'h01;
        in_a      = 32'(sent);
        in_b      = 32'hFFFF_FFFF - 32'(sent);
        out_ready = cyc[0];
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
          chk("stream_op", 64'(out_op), 64'h01);
          chk("stream_a",  64'(out_a),  64'(got));
          chk("stream_b",  64'(out_b),  64'(32'hFFFF_FFFF - 32'(got)));
          got++;
        end
        tick();
        if (acc) sent++;
      end
      chk("stream_done", 64'(got), 64'd10);
      in_valid = 1'b0; out_ready = 1'b0;
    end

    // Asynchronous reset in the middle of a cycle with 3 entries held.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 8'h04; in_a = 32'(100 + i); in_b = 32'(200 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("prefill_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("midreset");
    tick();
    rst_n = 1'b1;

`ifdef ALU_OPQ_OPCHECK_EN
    begin
      logic [7:0] ops [4];
      ops[0] = 8'h0A; ops[1] = 8'h0B; ops[2] = 8'hFF; ops[3] = 8'h03;
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1; in_op = ops[i]; in_a = 32'(i); in_b = 32'(i);
        chk("opchk_iready", 64'(in_ready), 64'd1);
        tick();
      end
      in_valid = 1'b0;
      chk("opchk_count", 64'(count), 64'd2);
      chk("opchk_illegal", 64'(illegal_cnt), 64'd2);
      chk("opchk_head0", 64'(out_op), 64'h0A);
      out_ready = 1'b1;
      tick();
      chk("opchk_head1", 64'(out_op), 64'h03);
      chk("opchk_head1_a", 64'(out_a), 64'd3);
      tick();
      out_ready = 1'b0;
      chk("opchk_empty", 64'(out_valid), 64'd0);
      for (int i = 0; i < 300; i++) begin
        in_valid = 1'b1; in_op = 8'(8'h0B + (i % 245));
        tick();
      end
      in_valid = 1'b0;
      chk("opchk_sat", 64'(illegal_cnt), 64'hFF);
      chk("opchk_sat_count", 64'(count), 64'd0);
    end
`else
    in_valid = 1'b1; in_op = 8'hFF; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    chk("noopchk_count", 64'(count), 64'd1);
    chk("noopchk_op", 64'(out_op), 64'hFF);
    chk("noopchk_a", 64'(out_a), 64'hDEAD_BEEF);
    chk("noopchk_illegal", 64'(illegal_cnt), 64'd0);
`endif

    // Randomized traffic against a queue model.
    do_reset();
    mq.delete();
    ill_model = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic exp_ready, do_push, do_pop, legal;
      req_t r;
      exp_ready = (mq.size() < DEPTH);
      chk("rnd_count",  64'(count),     64'(mq.size()));
      chk("rnd_iready", 64'(in_ready),  64'(exp_ready));
      chk("rnd_ovalid", 64'(out_valid), 64'(mq.size() != 0));
      chk("rnd_illegal", 64'(illegal_cnt), 64'(ill_model));
      if (mq.size() != 0) begin
        chk("rnd_op", 64'(out_op), 64'(mq[0].op));
        chk("rnd_a",  64'(out_a),  64'(mq[0].a));
        chk("rnd_b",  64'(out_b),  64'(mq[0].b));
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_op     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      in_a      = $urandom;
      in_b      = $urandom;
      r.op = in_op; r.a = in_a; r.b = in_b;
`ifdef ALU_OPQ_OPCHECK_EN
      legal = (in_op <= 8'h0A);
`else
      legal = 1'b1;
`endif
      do_push = in_valid && exp_ready;
      do_pop  = out_ready && (mq.size() != 0);
      tick();
      if (do_pop) void'(mq.pop_front());
      if (do_push && legal) mq.push_back(r);
`ifdef ALU_OPQ_OPCHECK_EN
      if (do_push && !legal && ill_model < 255) ill_model++;
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
